// File: rtl/bsram_arb_pkg.sv
// Shared types and constants for the BSRAM host/mapper arbiter.
package bsram_arb_pkg;

  // Default number of cycles a host access owns the BSRAM port (legal 1..7).
  localparam int ACCESS_CYCLES_DEF = 2;

  // Width of the access-cycle counter; 3 bits covers the full legal range.
  localparam int CNT_W = 3;

  // Host access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bsram_dirty_trk.sv
// Dirty-flag tracker: remembers that the mapper wrote BSRAM since the last
// clear. A set and a clear arriving in the same cycle resolve to set, so a
// write racing a save is never lost.
module bsram_dirty_trk
  import bsram_arb_pkg::*;
(
  input  logic mclk,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  output logic dirty_o
);

  logic dirty_q;

  // Dirty flop with set-over-clear priority.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= 1'b0;
    end else if (set_i) begin
      dirty_q <= 1'b1;
    end else if (clr_i) begin
      dirty_q <= 1'b0;
    end
  end

  assign dirty_o = dirty_q;

endmodule

// File: rtl/bsram_host_arb.sv
// BSRAM port arbiter between the active mapper and the host save/load engine.
// The mapper has absolute priority and passes straight through with no added
// latency. A single captured host byte access is played into cycles the mapper
// leaves idle; if the mapper reclaims the port mid-access, the access is
// abandoned and restarted from scratch later (writes are idempotent).
// Optional feature: define BSRAM_DIRTY_EN to build the mapper-write dirty flag;
// without it, dirty is tied low and dirty_clr is ignored.
module bsram_host_arb
  import bsram_arb_pkg::*;
#(
  parameter int AW            = 20,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic          mclk,
  input  logic          rst_n,
  // Mapper side
  input  logic [AW-1:0] map_addr,
  input  logic [7:0]    map_d,
  input  logic          map_ce_n,
  input  logic          map_oe_n,
  input  logic          map_we_n,
  input  logic [AW-1:0] bsram_mask,
  // Host save/load engine side
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_d,
  input  logic          host_we,
  output logic          host_ack,
  output logic [7:0]    host_q,
  output logic          host_busy,
  // External BSRAM
  output logic [AW-1:0] bsram_addr,
  output logic [7:0]    bsram_d,
  input  logic [7:0]    bsram_q,
  output logic          bsram_ce_n,
  output logic          bsram_oe_n,
  output logic          bsram_we_n,
  // Save tracking
  output logic          dirty,
  input  logic          dirty_clr
);

  // Counter value on the final cycle of an uninterrupted access.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       data_q;
  logic             we_q;
  logic             ack_q;
  logic [7:0]       q_q;

  // A request is only captured when nothing is outstanding; otherwise it is
  // dropped so the in-flight address/data stay intact.
  logic accept;
  assign accept = host_req && !pending_q;

  // Host access sequencer: capture, launch, count, complete or abort.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its peers; blocking here would chain updates within
  // one edge and break the timing the FSM relies on.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      q_q       <= '0;
    end else begin
      ack_q <= 1'b0;

      if (accept) begin
        addr_q    <= host_addr;
        data_q    <= host_d;
        we_q      <= host_we;
        pending_q <= 1'b1;
      end

      case (state_q)
        // DONE behaves like IDLE so a request accepted in the ack cycle can
        // launch straight away, giving one byte per ACCESS_CYCLES+1 cycles.
        IDLE, DONE: begin
          cnt_q <= '0;
          if ((pending_q || accept) && map_ce_n) begin
            state_q <= ACC;
          end else begin
            state_q <= IDLE;
          end
        end

        ACC: begin
          if (!map_ce_n) begin
            // Mapper reclaimed the port: abandon and retry from the top.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= DONE;
            cnt_q     <= '0;
            ack_q     <= 1'b1;
            pending_q <= 1'b0;
            // Read data is sampled on the last owned cycle, so a mapper
            // access landing in DONE cannot corrupt it.
            if (!we_q) begin
              q_q <= bsram_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // BSRAM bus mux: mapper wins, then an active host access, else parked.
  // NOTE: every output gets a default before the if/else chain so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bsram_addr = addr_q & bsram_mask;
    bsram_d    = data_q;
    bsram_ce_n = 1'b1;
    bsram_oe_n = 1'b1;
    bsram_we_n = 1'b1;

    if (!map_ce_n) begin
      bsram_addr = map_addr;
      bsram_d    = map_d;
      bsram_ce_n = map_ce_n;
      bsram_oe_n = map_oe_n;
      bsram_we_n = map_we_n;
    end else if (state_q == ACC) begin
      bsram_ce_n = 1'b0;
      bsram_oe_n = we_q;
      bsram_we_n = !we_q;
    end

    // Keep the SRAM deselected for the whole reset, even if the mapper drives.
    if (!rst_n) begin
      bsram_ce_n = 1'b1;
      bsram_oe_n = 1'b1;
      bsram_we_n = 1'b1;
    end
  end

  assign host_ack  = ack_q;
  assign host_q    = q_q;
  assign host_busy = pending_q;

`ifdef BSRAM_DIRTY_EN
  logic map_write;
  assign map_write = !map_ce_n && !map_we_n;

  bsram_dirty_trk u_dirty (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .set_i   (map_write),
    .clr_i   (dirty_clr),
    .dirty_o (dirty)
  );
`else
  // Feature compiled out: no flop, clear input deliberately unused.
  logic unused_dirty_clr;
  assign unused_dirty_clr = dirty_clr;
  assign dirty            = 1'b0;
`endif

endmodule

// File: tb/tb_bsram_host_arb.sv
// Self-checking bench for bsram_host_arb: directed scenarios with literal
// expectations, then randomized mapper/host traffic compared every cycle
// against a transaction-level model and a behavioural BSRAM.
module tb_bsram_host_arb;

  localparam int AW = 20;
  localparam int AC = 2;
`ifdef BSRAM_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] map_addr;
  logic [7:0]    map_d;
  logic          map_ce_n, map_oe_n, map_we_n;
  logic [AW-1:0] bsram_mask;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_d;
  logic          host_we;
  logic          host_ack;
  logic [7:0]    host_q;
  logic          host_busy;
  logic [AW-1:0] bsram_addr;
  logic [7:0]    bsram_d;
  logic [7:0]    bsram_q;
  logic          bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic          dirty;
  logic          dirty_clr;

  always #5 mclk = ~mclk;

  bsram_host_arb #(.AW(AW), .ACCESS_CYCLES(AC)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .map_addr   (map_addr),
    .map_d      (map_d),
    .map_ce_n   (map_ce_n),
    .map_oe_n   (map_oe_n),
    .map_we_n   (map_we_n),
    .bsram_mask (bsram_mask),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_d     (host_d),
    .host_we    (host_we),
    .host_ack   (host_ack),
    .host_q     (host_q),
    .host_busy  (host_busy),
    .bsram_addr (bsram_addr),
    .bsram_d    (bsram_d),
    .bsram_q    (bsram_q),
    .bsram_ce_n (bsram_ce_n),
    .bsram_oe_n (bsram_oe_n),
    .bsram_we_n (bsram_we_n),
    .dirty      (dirty),
    .dirty_clr  (dirty_clr)
  );

  // Behavioural BSRAM (64 KiB window); only drives data on an enabled read.
  logic [7:0] mem [0:65535];
  assign bsram_q = (!bsram_ce_n && !bsram_oe_n) ? mem[bsram_addr[15:0]] : 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A request completes once the mapper has been idle for AC+1 consecutive
  // cycles while it is outstanding (one launch cycle plus AC owned cycles);
  // any mapper cycle restarts that run. The host owns the bus on run 1..AC.
  bit            m_pend;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_d;
  bit            m_we;
  int            m_run;
  bit            m_ack;
  logic [7:0]    m_q;
  bit            m_dirty;
  bit            m_accept, m_hd;
  logic [AW-1:0] m_ha;

  task automatic model_reset();
    m_pend = 0; m_addr = '0; m_d = '0; m_we = 0; m_run = 0;
    m_ack = 0; m_q = '0; m_dirty = 0;
  endtask

  always @(negedge mclk) begin
    if (!rst_n) begin
      check("rst_strobes", {bsram_ce_n, bsram_oe_n, bsram_we_n}, 3'b111);
      check("rst_busy", host_busy, 1'b0);
      check("rst_ack", host_ack, 1'b0);
      check("rst_dirty", dirty, 1'b0);
      check("rst_host_q", host_q, 8'h00);
      model_reset();
    end else begin
      if (host_ack) ack_total++;
      check("busy", host_busy, m_pend);
      check("ack", host_ack, m_ack);
      check("host_q", host_q, m_q);
      check("dirty", dirty, m_dirty);

      m_ha = m_addr & bsram_mask;
      m_hd = m_pend && (m_run >= 1) && map_ce_n;
      if (!map_ce_n)
        check("bus_mapper", {bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n},
              {map_addr, map_d, map_ce_n, map_oe_n, map_we_n});
      else if (m_hd) begin
        check("bus_host", {bsram_addr, bsram_ce_n, bsram_oe_n, bsram_we_n},
              {m_ha, 1'b0, m_we, !m_we});
        if (m_we) check("bus_host_d", bsram_d, m_d);
      end else
        check("bus_idle", {bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n},
              {m_ha, m_d, 3'b111});

      // Memory contents follow whoever is writing this cycle.
      if (!map_ce_n && !map_we_n) mem[map_addr[15:0]] = map_d;
      if (m_hd && m_we) mem[m_ha[15:0]] = m_d;

      // Advance model to the next cycle.
      m_accept = host_req && !m_pend;
      m_ack = 0;
      if (m_hd && m_run == AC) begin
        if (!m_we) m_q = mem[m_ha[15:0]];
        m_ack = 1; m_pend = 0; m_run = 0;
      end else begin
        if (m_accept) begin
          m_addr = host_addr; m_d = host_d; m_we = host_we; m_pend = 1;
        end
        if (m_pend && map_ce_n) m_run++;
        else m_run = 0;
      end
      if (DIRTY_EN) begin
        if (!map_ce_n && !map_we_n) m_dirty = 1;
        else if (dirty_clr) m_dirty = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Issue one host access with the mapper idle and measure its bus footprint.
  task automatic host_op(input logic [AW-1:0] a, input logic [7:0] d, input logic we,
                         output int lat, output int oe_lo, output int we_lo,
                         output logic [AW-1:0] waddr);
    host_addr = a; host_d = d; host_we = we; host_req = 1'b1;
    lat = -1; oe_lo = 0; we_lo = 0; waddr = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge mclk);
      if (!bsram_oe_n) oe_lo++;
      if (!bsram_we_n) begin we_lo++; waddr = bsram_addr; end
      if (host_ack) begin lat = k; break; end
      @(posedge mclk); #1;
      host_req = 1'b0;
    end
    host_req = 1'b0;
    check("op_completed", (lat >= 0), 1'b1);
    tick();
  endtask

  int lat, oe_lo, we_lo, ack_k, acks;
  logic [AW-1:0] waddr;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[16'h0123] = 8'h5A;
    mem[16'h0456] = 8'h3C;
    mem[16'h0300] = 8'h99;
    mem[16'h0500] = 8'h6E;

    rst_n = 1'b0; map_addr = '0; map_d = '0; map_ce_n = 1'b1; map_oe_n = 1'b1;
    map_we_n = 1'b1; bsram_mask = 20'h0FFFF; host_req = 1'b0; host_addr = '0;
    host_d = '0; host_we = 1'b0; dirty_clr = 1'b0;

    // Reset state, pinned literally.
    @(negedge mclk);
    check("reset_ack", host_ack, 1'b0);
    check("reset_busy", host_busy, 1'b0);
    check("reset_q", host_q, 8'h00);
    check("reset_strobes", {bsram_ce_n, bsram_oe_n, bsram_we_n}, 3'b111);
    tick();
    rst_n = 1'b1;
    tick();

    // Uncontended read.
    host_op(20'h00123, 8'h00, 1'b0, lat, oe_lo, we_lo, waddr);
    check("rd_latency", lat, AC + 1);
    check("rd_data", host_q, 8'h5A);
    check("rd_oe_cycles", oe_lo, AC);

    // Masked write, then read back.
    bsram_mask = 20'h07FFF;
    host_op(20'h1FFFF, 8'hA5, 1'b1, lat, oe_lo, we_lo, waddr);
    check("wr_latency", lat, AC + 1);
    check("wr_addr_masked", waddr, 20'h07FFF);
    check("wr_we_cycles", we_lo, AC);
    host_op(20'h1FFFF, 8'h00, 1'b0, lat, oe_lo, we_lo, waddr);
    check("wr_readback", host_q, 8'hA5);
    bsram_mask = 20'h0FFFF;

    // Mapper steals the port in the 2nd owned cycle.
    ack_k = -1;
    for (int k = 0; k < 16; k++) begin
      host_req = (k == 0); host_addr = 20'h00456; host_we = 1'b0;
      map_ce_n = !(k == 2 || k == 3); map_oe_n = map_ce_n; map_addr = 20'h00ABC;
      @(negedge mclk);
      if (k == 2) check("abort_bus_switch", {bsram_addr, bsram_oe_n}, {20'h00ABC, 1'b0});
      if (host_ack && ack_k < 0) ack_k = k;
      tick();
    end
    map_ce_n = 1'b1; map_oe_n = 1'b1; host_req = 1'b0;
    check("abort_ack_cycle", ack_k, 7);
    check("abort_data", host_q, 8'h3C);

    // Second request while busy is ignored.
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      host_req = (k <= 1); host_we = 1'b1;
      host_addr = (k == 0) ? 20'h00200 : 20'h00300;
      host_d    = (k == 0) ? 8'h11 : 8'h22;
      @(negedge mclk);
      if (k == 1) check("busy_while_pending", host_busy, 1'b1);
      if (host_ack) acks++;
      tick();
    end
    host_req = 1'b0;
    check("busy_single_ack", acks, 1);
    host_op(20'h00200, 8'h00, 1'b0, lat, oe_lo, we_lo, waddr);
    check("busy_first_data", host_q, 8'h11);
    host_op(20'h00300, 8'h00, 1'b0, lat, oe_lo, we_lo, waddr);
    check("busy_second_untouched", host_q, 8'h99);

    // Dirty: set beats clear, lone clear clears.
    map_ce_n = 1'b0; map_we_n = 1'b0; map_addr = 20'h00010; map_d = 8'h77; dirty_clr = 1'b1;
    tick();
    map_ce_n = 1'b1; map_we_n = 1'b1; dirty_clr = 1'b0;
    @(negedge mclk);
    check("dirty_set_wins", dirty, DIRTY_EN);
    @(posedge mclk); #1;
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    @(negedge mclk);
    check("dirty_cleared", dirty, 1'b0);
    tick();

    // Reset during ACC: request lost, strobes forced high even with mapper on.
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      host_req = (k == 0); host_addr = 20'h00500; host_we = 1'b0;
      rst_n = !(k == 2);
      map_ce_n = !(k == 2); map_oe_n = map_ce_n;
      @(negedge mclk);
      if (k == 2) begin
        check("rstacc_strobes", {bsram_ce_n, bsram_oe_n, bsram_we_n}, 3'b111);
        check("rstacc_busy", host_busy, 1'b0);
      end
      if (host_ack) acks++;
      tick();
    end
    host_req = 1'b0; rst_n = 1'b1; map_ce_n = 1'b1; map_oe_n = 1'b1;
    check("rstacc_no_ack", acks, 0);
    host_op(20'h00500, 8'h00, 1'b0, lat, oe_lo, we_lo, waddr);
    check("rstacc_retry_latency", lat, AC + 1);
    check("rstacc_retry_data", host_q, 8'h6E);

    // Randomized traffic against the model.
    acks = ack_total;
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 999) != 0);
      map_ce_n   = ($urandom_range(0, 99) >= 35);
      map_we_n   = $urandom_range(0, 1) != 0;
      map_oe_n   = !map_we_n;
      map_addr   = {4'h0, 16'($urandom)};
      map_d      = 8'($urandom);
      host_req   = ($urandom_range(0, 99) < 30);
      host_addr  = AW'($urandom);
      host_d     = 8'($urandom);
      host_we    = $urandom_range(0, 1) != 0;
      dirty_clr  = ($urandom_range(0, 9) == 0);
      bsram_mask = (n < 1500) ? 20'h0FFFF : 20'h00FFF;
      tick();
    end
    rst_n = 1'b1; map_ce_n = 1'b1; map_we_n = 1'b1; map_oe_n = 1'b1;
    host_req = 1'b0; dirty_clr = 1'b0;
    repeat (10) tick();
    check("rand_acks_seen", (ack_total - acks > 50), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
